// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select generator and load-use stall controller.
// Keeps a shadow {valid, rd, regwrite, memread} copy of the EX/MEM/WB stages, advanced with ID/EX.
module fwd_hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              IdValid,
   input  logic [REG_AW-1:0] IdRs,
   input  logic [REG_AW-1:0] IdRt,
   input  logic              IdUsesRs,
   input  logic              IdUsesRt,
   input  logic [REG_AW-1:0] IdRd,
   input  logic              IdRegWrite,
   input  logic              IdMemRead,
   input  logic              Hold,
   input  logic              Flush,
   output logic [1:0]        ForwardA,
   output logic [1:0]        ForwardB,
   output logic              Stall,
   output logic [CNT_W-1:0]  StallCount
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } entry_t;

   localparam entry_t BUBBLE = {($bits(entry_t)){1'b0}};

   entry_t           ex_r, mem_r, wb_r, ex_nxt_s;
   logic [1:0]       fwd_a_r, fwd_b_r, sel_a_s, sel_b_s, fwd_a_nxt_s, fwd_b_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic             hazard_s, stall_s;
   logic             wb_unused_s;

   function automatic logic is_writer(input entry_t e);
      return e.valid && e.regwrite && (e.rd != {REG_AW{1'b0}});
   endfunction

   // EX match beats MEM match; register 0 is excluded through is_writer
   function automatic logic [1:0] fwd_sel(input logic uses, input logic [REG_AW-1:0] src,
                                          input entry_t ex, input entry_t mem);
      logic [1:0] sel;
      sel = 2'b00;
      if (!uses) begin
         sel = 2'b00;
      end else if (is_writer(ex) && (ex.rd == src)) begin
         sel = 2'b10;
      end else if (is_writer(mem) && (mem.rd == src)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Hazard detection, operand selects and next EX entry
   always_comb begin
      hazard_s    = 1'b0;
      stall_s     = 1'b0;
      sel_a_s     = fwd_sel(IdUsesRs, IdRs, ex_r, mem_r);
      sel_b_s     = fwd_sel(IdUsesRt, IdRt, ex_r, mem_r);
      ex_nxt_s    = BUBBLE;
      fwd_a_nxt_s = 2'b00;
      fwd_b_nxt_s = 2'b00;
      if (IdValid && ex_r.memread && is_writer(ex_r) &&
          ((IdUsesRs && (IdRs == ex_r.rd)) || (IdUsesRt && (IdRt == ex_r.rd)))) begin
         hazard_s = 1'b1;
      end else begin
         hazard_s = 1'b0;
      end
      stall_s = hazard_s && !Flush;
      if (stall_s || Flush || !IdValid) begin
         ex_nxt_s    = BUBBLE;
         fwd_a_nxt_s = 2'b00;
         fwd_b_nxt_s = 2'b00;
      end else begin
         ex_nxt_s    = '{valid: IdValid, rd: IdRd, regwrite: IdRegWrite, memread: IdMemRead};
         fwd_a_nxt_s = sel_a_s;
         fwd_b_nxt_s = sel_b_s;
      end
   end

   // Shadow pipeline advance, registered selects and saturating stall counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_r    <= BUBBLE;
         mem_r   <= BUBBLE;
         wb_r    <= BUBBLE;
         fwd_a_r <= 2'b00;
         fwd_b_r <= 2'b00;
         cnt_r   <= {CNT_W{1'b0}};
      end else if (Hold) begin
         ex_r    <= ex_r;
         mem_r   <= mem_r;
         wb_r    <= wb_r;
         fwd_a_r <= fwd_a_r;
         fwd_b_r <= fwd_b_r;
         cnt_r   <= cnt_r;
      end else begin
         ex_r    <= ex_nxt_s;
         mem_r   <= ex_r;
         wb_r    <= mem_r;
         fwd_a_r <= fwd_a_nxt_s;
         fwd_b_r <= fwd_b_nxt_s;
         if (stall_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // WB slot is shadow state only; the register file covers WB-to-ID through write-through
   assign wb_unused_s = ^wb_r;

   assign ForwardA   = fwd_a_r;
   assign ForwardB   = fwd_b_r;
   assign Stall      = stall_s;
   assign StallCount = cnt_r;

endmodule
